// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the five-stage pipeline datapath and the hazard controller.
// master = pipeline datapath side, slave = pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_branch_taken;
  logic       ex_md_start;

  logic       pc_we;
  logic       ifid_we;
  logic       ifid_flush;
  logic       idex_we;
  logic       idex_flush;
  logic       exmem_we;
  logic       exmem_flush;
  logic       memwb_we;
  logic       memwb_flush;
  logic       md_busy;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read, ex_branch_taken, ex_md_start,
    input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
           exmem_we, exmem_flush, memwb_we, memwb_flush, md_busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read, ex_branch_taken, ex_md_start,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
           exmem_we, exmem_flush, memwb_we, memwb_flush, md_busy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, multi-cycle mul/div freeze.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
//
// state    | meaning
// S_RUN    | normal issue; mul/div start > branch > load-use
// S_MDWAIT | mul/div in EX, front of pipe frozen, md_cnt counts remaining cycles
// S_MDDONE | mul/div result advances; ex_md_start ignored so the op does not restart
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic                    Clk,
  input  logic                    Rst,
  pipeline_hazard_ctrl_if.slave   hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]        stall_cycles,
  output logic [CNT_W-1:0]        flush_events
`endif
);

  if (MD_LATENCY < 2 || MD_LATENCY > 255 || CNT_W < 1) begin : g_bad_param
    $error("pipeline_hazard_ctrl: illegal MD_LATENCY or CNT_W");
  end

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_MDWAIT = 2'd1,
    S_MDDONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] md_cnt, md_cnt_nxt;
  logic       lu;
  logic       do_md, do_br, do_lu;

  assign lu = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
              ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= S_RUN;
      md_cnt <= 8'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    do_md      = 1'b0;
    do_br      = 1'b0;
    do_lu      = 1'b0;
    if (!Rst) begin
      case (state)
        S_RUN: begin
          if (hz.ex_md_start) begin
            do_md      = 1'b1;
            state_nxt  = S_MDWAIT;
            md_cnt_nxt = 8'(MD_LATENCY - 1);
          end else if (hz.ex_branch_taken) begin
            do_br = 1'b1;
          end else if (lu) begin
            do_lu = 1'b1;
          end
        end
        S_MDWAIT: begin
          do_md      = 1'b1;
          md_cnt_nxt = md_cnt - 8'd1;
          // <=1 rather than ==1 so a corrupted count can never wedge the freeze
          if (md_cnt <= 8'd1) begin
            state_nxt  = S_MDDONE;
            md_cnt_nxt = 8'd0;
          end
        end
        S_MDDONE: begin
          state_nxt = S_RUN;
          if (hz.ex_branch_taken) begin
            do_br = 1'b1;
          end else if (lu) begin
            do_lu = 1'b1;
          end
        end
        default: begin
          state_nxt  = S_RUN;
          md_cnt_nxt = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    hz.pc_we       = 1'b1;
    hz.ifid_we     = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_we     = 1'b1;
    hz.idex_flush  = 1'b0;
    hz.exmem_we    = 1'b1;
    hz.exmem_flush = 1'b0;
    hz.memwb_we    = 1'b1;
    hz.memwb_flush = 1'b0;
    hz.md_busy     = 1'b0;
    if (Rst) begin
      hz.pc_we       = 1'b0;
      hz.ifid_flush  = 1'b1;
      hz.idex_flush  = 1'b1;
      hz.exmem_flush = 1'b1;
      hz.memwb_flush = 1'b1;
    end else if (do_md) begin
      hz.pc_we       = 1'b0;
      hz.ifid_we     = 1'b0;
      hz.idex_we     = 1'b0;
      hz.exmem_flush = 1'b1;
      hz.md_busy     = 1'b1;
    end else if (do_br) begin
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (do_lu) begin
      hz.pc_we      = 1'b0;
      hz.ifid_we    = 1'b0;
      hz.idex_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!hz.pc_we) stall_cycles <= stall_cycles + 1'b1;
      if (do_br)     flush_events <= flush_events + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  pipeline_hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(32)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .hz  (hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, memwb_we, memwb_flush, md_busy}
  localparam logic [9:0] DEF = 10'b1101010100;
  localparam logic [9:0] LU  = 10'b0001110100;
  localparam logic [9:0] BR  = 10'b1111110100;
  localparam logic [9:0] MD  = 10'b0000011101;
  localparam logic [9:0] RST = 10'b0111111110;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs, rt;
    logic       uses_rt;
    logic [4:0] rd;
    logic       mem_read, br, md;
    logic [9:0] exp;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mkv(string name, logic rst, logic [4:0] rs, logic [4:0] rt,
                               logic uses_rt, logic [4:0] rd, logic mem_read,
                               logic br, logic md, logic [9:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt;
    v.rd = rd; v.mem_read = mem_read; v.br = br; v.md = md; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    vec_t e;
    logic [9:0] act;
    @(posedge Clk);
    #1;
    Rst                = v.rst;
    hz.id_rs           = v.rs;
    hz.id_rt           = v.rt;
    hz.id_uses_rt      = v.uses_rt;
    hz.ex_rd           = v.rd;
    hz.ex_mem_read     = v.mem_read;
    hz.ex_branch_taken = v.br;
    hz.ex_md_start     = v.md;
    sb.push_back(v);
    @(negedge Clk);
    e   = sb.pop_front();
    act = {hz.pc_we, hz.ifid_we, hz.ifid_flush, hz.idex_we, hz.idex_flush,
           hz.exmem_we, hz.exmem_flush, hz.memwb_we, hz.memwb_flush, hz.md_busy};
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
    end
  endtask

  initial begin
    hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rt = 1'b0; hz.ex_rd = '0;
    hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0; hz.ex_md_start = 1'b0;

    //             name            rst rs     rt     ur  rd     mr  br  md  exp
    tbl.push_back(mkv("reset",      1, 5'd0,  5'd0,  0, 5'd0,  0,  0,  0,  RST));
    tbl.push_back(mkv("idle",       0, 5'd0,  5'd0,  0, 5'd0,  0,  0,  0,  DEF));
    tbl.push_back(mkv("lu_rs",      0, 5'd5,  5'd0,  0, 5'd5,  1,  0,  0,  LU));
    tbl.push_back(mkv("after_lu",   0, 5'd5,  5'd0,  0, 5'd5,  0,  0,  0,  DEF));
    tbl.push_back(mkv("zero_reg",   0, 5'd0,  5'd0,  1, 5'd0,  1,  0,  0,  DEF));
    tbl.push_back(mkv("lu_rt",      0, 5'd1,  5'd7,  1, 5'd7,  1,  0,  0,  LU));
    tbl.push_back(mkv("rt_unused",  0, 5'd1,  5'd7,  0, 5'd7,  1,  0,  0,  DEF));
    tbl.push_back(mkv("no_load",    0, 5'd5,  5'd5,  1, 5'd5,  0,  0,  0,  DEF));
    tbl.push_back(mkv("br_beats_lu",0, 5'd5,  5'd0,  0, 5'd5,  1,  1,  0,  BR));
    tbl.push_back(mkv("br_only",    0, 5'd2,  5'd3,  1, 5'd9,  0,  1,  0,  BR));
    tbl.push_back(mkv("rd_differs", 0, 5'd3,  5'd4,  1, 5'd9,  1,  0,  0,  DEF));
    tbl.push_back(mkv("lu_rd31",    0, 5'd0,  5'd31, 1, 5'd31, 1,  0,  0,  LU));
    foreach (tbl[i]) apply(tbl[i]);

    // mul/div held high: four frozen cycles, then S_MDDONE with defaults
    for (int i = 0; i < 4; i++) apply(mkv("md_freeze", 0, 0, 0, 0, 0, 0, 0, 1, MD));
    apply(mkv("md_done_held", 0, 0, 0, 0, 0, 0, 0, 1, DEF));
    apply(mkv("md_back_run",  0, 0, 0, 0, 0, 0, 0, 0, DEF));

    // branch and load-use ignored while waiting, honoured in S_MDDONE
    apply(mkv("md_start2",    0, 5'd5, 0, 0, 5'd5, 1, 1, 1, MD));
    for (int i = 0; i < 3; i++) apply(mkv("md_wait_ign", 0, 5'd5, 0, 0, 5'd5, 1, 1, 0, MD));
    apply(mkv("md_done_br",   0, 5'd5, 0, 0, 5'd5, 1, 1, 1, BR));
    apply(mkv("run_lu",       0, 5'd5, 0, 0, 5'd5, 1, 0, 0, LU));
    apply(mkv("md_then_lu",   0, 5'd6, 0, 0, 5'd6, 1, 0, 1, MD));
    for (int i = 0; i < 3; i++) apply(mkv("md_wait2", 0, 5'd6, 0, 0, 5'd6, 1, 0, 1, MD));
    apply(mkv("md_done_lu",   0, 5'd6, 0, 0, 5'd6, 1, 0, 1, LU));

    // reset during the second S_MDWAIT cycle abandons the op
    apply(mkv("md_start3",    0, 0, 0, 0, 0, 0, 0, 1, MD));
    apply(mkv("md_wait_1",    0, 0, 0, 0, 0, 0, 0, 1, MD));
    apply(mkv("rst_mid_md",   1, 0, 0, 0, 0, 0, 0, 1, RST));
    apply(mkv("post_rst",     0, 0, 0, 0, 0, 0, 0, 0, DEF));
    apply(mkv("post_rst2",    0, 0, 0, 0, 0, 0, 0, 0, DEF));
    apply(mkv("md_restart",   0, 0, 0, 0, 0, 0, 0, 1, MD));

`ifdef HAZARD_PERF_CNT_EN
    apply(mkv("perf_rst",     1, 0, 0, 0, 0, 0, 0, 0, RST));
    apply(mkv("perf_lu",      0, 5'd5, 0, 0, 5'd5, 1, 0, 0, LU));
    apply(mkv("perf_br",      0, 0, 0, 0, 0, 0, 1, 0, BR));
    for (int i = 0; i < 4; i++) apply(mkv("perf_md", 0, 0, 0, 0, 0, 0, 0, 1, MD));
    apply(mkv("perf_done",    0, 0, 0, 0, 0, 0, 0, 1, DEF));
    apply(mkv("perf_idle",    0, 0, 0, 0, 0, 0, 0, 0, DEF));
    checks++;
    if (stall_cycles !== 32'd5) begin
      errors++;
      $display("FAIL stall_cycles: got %0d expected 5", stall_cycles);
    end
    checks++;
    if (flush_events !== 32'd1) begin
      errors++;
      $display("FAIL flush_events: got %0d expected 1", flush_events);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
